// File: rtl/fetch_queue_pkg.sv
// Shared constants and entry layout for the instruction fetch queue.
package fetch_queue_pkg;

  localparam int INST_W = 32;
  localparam int FQ_ADDR_W = 6;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [INST_W-1:0]    inst;
    logic [FQ_ADDR_W-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Small circular FIFO with flush; head entry is read combinationally from the storage flops.
module fq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & !flush & (count_q != '0);
    // A full queue still accepts a write when the head leaves in the same cycle.
    do_push  = push & !flush & ((count_q != (PTR_W+1)'(DEPTH)) | do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, queues returned instructions with their PC,
// and hands them to decode over valid/ready; redirect flushes and restarts fetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int               ADDR_W   = FQ_ADDR_W,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [INST_W-1:0]         imem_rdata,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INST_W-1:0]         out_inst,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              push, pop;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            wr_entry, head;
  logic              empty;

  assign empty = (fifo_count == '0);

  always_comb begin
    out_valid = !empty & !redirect;
    pop       = out_valid & out_ready;
    push      = !redirect & ((fifo_count != CNT_W'(DEPTH)) | pop);
    wr_entry  = '{inst: imem_rdata, pc: fetch_pc_q};
    fetch_pc_d = fetch_pc_q;
    // Masking keeps the PC word-aligned regardless of the low target bits.
    if (redirect)  fetch_pc_d = redirect_pc & ~ADDR_W'(3);
    else if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_pc_q <= RESET_PC;
    else     fetch_pc_q <= fetch_pc_d;
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count)
  );

  // Stale storage is hidden whenever the queue is empty.
  assign out_inst  = empty ? NOP_INST : head.inst;
  assign out_pc    = empty ? '0 : head.pc;
  assign imem_addr = fetch_pc_q;
  assign count     = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an address-tagged instruction memory model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [5:0]  redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [5:0]  out_pc;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return 32'hC0DE_0000 | {26'd0, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_queue #(.ADDR_W(6), .DEPTH(4), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .count(count)
  );

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; out_ready = rdy;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_inst !== NOP_INST) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", out_inst, NOP_INST); end
    n_checks++; if (out_pc !== 6'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", out_pc); end
    n_checks++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", imem_addr); end
    $display("reset: count=%0d valid=%b inst=%h pc=%h addr=%h", count, out_valid, out_inst, out_pc, imem_addr);
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 8; i++) begin
      logic [5:0] epc;
      epc = 6'(4 * i);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, epc); end
      n_checks++; if (out_inst !== mem_word(epc)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h expected %h", i, out_inst, mem_word(epc)); end
      n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count); end
      $display("stream: pc=%h inst=%h count=%0d", out_pc, out_inst, count);
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    for (int k = 1; k <= 10; k++) begin
      logic [2:0] ecnt;
      ecnt = (k < 4) ? 3'(k) : 3'd4;
      @(negedge clk);
      n_checks++; if (count !== ecnt) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d expected %0d", k, count, ecnt); end
      n_checks++; if (imem_addr !== {ecnt, 2'b00}) begin n_fail++; $display("FAIL bp_addr[%0d]: got %h expected %h", k, imem_addr, {ecnt, 2'b00}); end
      n_checks++; if (out_pc !== 6'd0) begin n_fail++; $display("FAIL bp_pc[%0d]: got %h expected 00", k, out_pc); end
      $display("stall: count=%0d addr=%h pc=%h", count, imem_addr, out_pc);
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      logic [5:0] epc, eaddr;
      epc = 6'(4 * j);
      eaddr = 6'(16 + 4 * j);
      #1;
      n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL full_pc[%0d]: got %h expected %h", j, out_pc, epc); end
      n_checks++; if (out_inst !== mem_word(epc)) begin n_fail++; $display("FAIL full_inst[%0d]: got %h expected %h", j, out_inst, mem_word(epc)); end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count[%0d]: got %0d expected 4", j, count); end
      n_checks++; if (imem_addr !== eaddr) begin n_fail++; $display("FAIL full_addr[%0d]: got %h expected %h", j, imem_addr, eaddr); end
      $display("drain: pc=%h count=%0d addr=%h", out_pc, count, imem_addr);
      @(negedge clk);
    end
  endtask

  task automatic test_redirect;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count: got %0d expected 3", count); end
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 6'h2A;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid_gate: got %b expected 0", out_valid); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_flush_count: got %0d expected 0", count); end
    n_checks++; if (imem_addr !== 6'h28) begin n_fail++; $display("FAIL redir_addr: got %h expected 28", imem_addr); end
    n_checks++; if (out_inst !== NOP_INST) begin n_fail++; $display("FAIL redir_empty_inst: got %h expected %h", out_inst, NOP_INST); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL redir_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_pc !== 6'h28) begin n_fail++; $display("FAIL redir_pc: got %h expected 28", out_pc); end
    n_checks++; if (out_inst !== mem_word(6'h28)) begin n_fail++; $display("FAIL redir_inst: got %h expected %h", out_inst, mem_word(6'h28)); end
    $display("redirect 2A: pc=%h inst=%h", out_pc, out_inst);
    // Two consecutive redirects: only the second target should survive.
    redirect = 1'b1; redirect_pc = 6'h10;
    @(negedge clk);
    redirect_pc = 6'h31;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 6'h30) begin n_fail++; $display("FAIL b2b_addr: got %h expected 30", imem_addr); end
    @(negedge clk);
    n_checks++; if (out_pc !== 6'h30) begin n_fail++; $display("FAIL b2b_pc: got %h expected 30", out_pc); end
    $display("redirect 10,31: addr=30 pc=%h", out_pc);
  endtask

  task automatic test_wrap_async_reset;
    do_reset(1'b1);
    redirect = 1'b1; redirect_pc = 6'h34;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      logic [5:0] epc;
      epc = 6'(6'h34 + 4 * i);
      n_checks++; if (out_pc !== epc) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, out_pc, epc); end
      $display("wrap: pc=%h", out_pc);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_inst !== NOP_INST) begin n_fail++; $display("FAIL arst_inst: got %h expected %h", out_inst, NOP_INST); end
    n_checks++; if (out_pc !== 6'd0) begin n_fail++; $display("FAIL arst_pc: got %h expected 00", out_pc); end
    n_checks++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL arst_addr: got %h expected 00", imem_addr); end
    $display("async reset: count=%0d valid=%b addr=%h", count, out_valid, imem_addr);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_pc !== 6'd0 || count !== 3'd1) begin n_fail++; $display("FAIL arst_resume: got pc=%h count=%0d expected pc=00 count=1", out_pc, count); end
    $display("resume: pc=%h count=%0d", out_pc, count);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
